alarm_sequencer: RTL

Sequences the alarm output from the running time, the alarm time and the user buttons (enable, snooze, dismiss).
- Sits between the time/alarm counters and the alarm output stage, in the 5 MHz domain.
- Replaces the simple alarm-on decision with a state machine that provides snooze, auto-timeout and retrigger suppression.
- Inputs are the BCD time and alarm values, a 1 Hz single-cycle tick, and debounced single-cycle button pulses.

---
 rtl/alarm_sequencer_pkg.sv | 24 ++
 rtl/second_timer.sv | 30 +++
 rtl/alarm_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_pkg.sv
// Shared types and constants for the alarm sequencer: FSM state codes,
// counter widths and the snooze-length conversion from minutes to seconds.
package alarm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_ARMED     = 3'd1,
    ST_RINGING   = 3'd2,
    ST_SNOOZE    = 3'd3,
    ST_DISMISSED = 3'd4
  } state_t;

  localparam int SNOOZE_W = 12;
  localparam int RING_W   = 12;

  localparam int SNOOZE_MINUTES_DEFAULT = 9;

  function automatic logic [SNOOZE_W-1:0] snooze_ticks(input int minutes);
    return SNOOZE_W'(minutes * 60);
  endfunction

  localparam logic [SNOOZE_W-1:0] SNOOZE_TICKS = snooze_ticks(SNOOZE_MINUTES_DEFAULT);

endpackage

// File: rtl/second_timer.sv
// Loadable down-counter stepped by a once-per-second tick; o_Done flags the
// tick that takes the count from 1 to 0, so the owner can act on that same edge.
module second_timer
  import alarm_sequencer_pkg::*;
#(
  parameter int W = SNOOZE_W
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Value,
  input  logic         i_Tick,
  output logic         o_Done
);

  logic [W-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Load_Value;
    end else if (i_Tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign o_Done = i_Tick && !i_Load && (count == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm FSM: arms, rings on the rising edge of a time/alarm match, snoozes,
// auto-dismisses after a ring timeout and suppresses retrigger within the minute.
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int SNOOZE_MINUTES   = 9,
  parameter int RING_TIMEOUT_SEC = 300,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Second_Pulse,
  input  logic        i_Alarm_Enable,
  input  logic [23:0] i_Time,
  input  logic        i_Time_PM,
  input  logic [15:0] i_Alarm_Time,
  input  logic        i_Alarm_PM,
  input  logic        i_Snooze,
  input  logic        i_Dismiss,
  output logic        o_Alarm_On,
  output logic        o_Ringing,
  output logic        o_Snoozing,
  output logic        o_Alarm_Enabled,
  output logic [2:0]  o_Snooze_Count,
  output logic [2:0]  o_State
);

  localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD  = snooze_ticks(SNOOZE_MINUTES);
  localparam logic [RING_W-1:0]   RING_LIMIT   = RING_W'(RING_TIMEOUT_SEC);
  localparam logic [2:0]          SNOOZE_LIMIT = 3'(MAX_SNOOZES);

  state_t              state, state_nxt;
  logic                match, r_Match, trigger;
  logic [RING_W-1:0]   ring_cnt, ring_cnt_nxt;
  logic [2:0]          snooze_cnt, snooze_cnt_nxt;
  logic                alarm_on, alarm_on_nxt;
  logic                snooze_ok, ring_timeout;
  logic                snooze_load, snooze_tick, snooze_done;
  logic                unused_seconds;

  // Seconds never take part in the match; the minute granularity is the point.
  assign unused_seconds = ^i_Time[7:0];

  assign match        = (i_Time[23:8] == i_Alarm_Time) && (i_Time_PM == i_Alarm_PM);
  assign trigger      = match && !r_Match;
  assign snooze_ok    = i_Snooze && (snooze_cnt < SNOOZE_LIMIT);
  assign ring_timeout = (ring_cnt == RING_LIMIT);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= ST_DISABLED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!i_Alarm_Enable) begin
      state_nxt = ST_DISABLED;
    end else begin
      unique case (state)
        ST_DISABLED:  state_nxt = ST_ARMED;
        ST_ARMED:     if (trigger) state_nxt = ST_RINGING;
        ST_RINGING: begin
          if (i_Dismiss || ring_timeout) state_nxt = ST_DISMISSED;
          else if (snooze_ok)            state_nxt = ST_SNOOZE;
        end
        ST_SNOOZE: begin
          if (i_Dismiss)        state_nxt = ST_DISMISSED;
          else if (snooze_done) state_nxt = ST_RINGING;
        end
        ST_DISMISSED: if (!match) state_nxt = ST_ARMED;
        default:      state_nxt = ST_DISABLED;
      endcase
    end
  end

  // Counters and buzzer drive follow the transition being taken this cycle.
  always_comb begin
    ring_cnt_nxt   = ring_cnt;
    snooze_cnt_nxt = snooze_cnt;
    alarm_on_nxt   = 1'b0;
    snooze_load    = 1'b0;
    if (state_nxt == ST_DISABLED) begin
      ring_cnt_nxt   = '0;
      snooze_cnt_nxt = '0;
    end else if (state_nxt == ST_RINGING && state != ST_RINGING) begin
      ring_cnt_nxt = '0;
      alarm_on_nxt = 1'b1;
    end else if (state_nxt == ST_RINGING) begin
      alarm_on_nxt = alarm_on;
      if (i_Second_Pulse) begin
        alarm_on_nxt = !alarm_on;
        if (ring_cnt != '1) ring_cnt_nxt = ring_cnt + RING_W'(1);
      end
    end else if (state_nxt == ST_SNOOZE && state == ST_RINGING) begin
      snooze_cnt_nxt = snooze_cnt + 3'd1;
      snooze_load    = 1'b1;
    end else if (state_nxt == ST_DISMISSED) begin
      snooze_cnt_nxt = '0;
    end
  end

  assign snooze_tick = i_Second_Pulse && (state == ST_SNOOZE);

  second_timer #(
    .W(SNOOZE_W)
  ) u_snooze_timer (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Load       (snooze_load || !i_Alarm_Enable),
    .i_Load_Value (snooze_load ? SNOOZE_LOAD : '0),
    .i_Tick       (snooze_tick),
    .o_Done       (snooze_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Match         <= 1'b0;
      ring_cnt        <= '0;
      snooze_cnt      <= '0;
      alarm_on        <= 1'b0;
      o_Ringing       <= 1'b0;
      o_Snoozing      <= 1'b0;
      o_Alarm_Enabled <= 1'b0;
    end else begin
      r_Match         <= match;
      ring_cnt        <= ring_cnt_nxt;
      snooze_cnt      <= snooze_cnt_nxt;
      alarm_on        <= alarm_on_nxt;
      o_Ringing       <= (state_nxt == ST_RINGING);
      o_Snoozing      <= (state_nxt == ST_SNOOZE);
      o_Alarm_Enabled <= (state_nxt != ST_DISABLED);
    end
  end

  assign o_Alarm_On     = alarm_on;
  assign o_Snooze_Count = snooze_cnt;
  assign o_State        = state;

endmodule
